// File: rtl/loop_pkg.sv
// Shared types and constants for the counted-loop accumulate engine.
// Holds the FSM state encoding and the body-function mode selectors.
package loop_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_TEST = 3'd2,
        S_BODY = 3'd3,
        S_INCR = 3'd4,
        S_EXIT = 3'd5,
        S_DONE = 3'd6
    } loop_state_t;

    localparam logic MODE_SUM = 1'b0;
    localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/loop_body_fn.sv
// Loop body function f(i), purely combinational.
// Ports: mode (MODE_SUM/MODE_SQR), i (loop index), f (result, WIDTH bits).
module loop_body_fn
    import loop_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] f
);

    // The square is evaluated in WIDTH context, keeping only the low
    // WIDTH bits of the full product.
    always_comb begin
        f = i;
        case (mode)
            MODE_SUM: f = i;
            MODE_SQR: f = i * i;
            default:  f = i;
        endcase
    end

endmodule

// File: rtl/loop_accum_engine.sv
// Counted-loop kernel: for (i=lo; i<hi; i+=step) acc+=f(i); ret=acc+offset.
// Ports: clk, rst_n, start, abort, mode, lo, hi, step, offset in;
//        busy, finish, ret, iters, wrapped out (all registered).
module loop_accum_engine
    import loop_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] offset,
    output logic             busy,
    output logic             finish,
    output logic [WIDTH-1:0] ret,
    output logic [CNT_W-1:0] iters,
    output logic             wrapped
);

    loop_state_t state_q;
    loop_state_t state_d;

    logic             mode_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] offset_q;
    logic [WIDTH-1:0] i_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] f_val;
    logic [WIDTH:0]   inc;
    logic             latch;
    logic             kill;

    loop_body_fn #(.WIDTH(WIDTH)) u_body_fn (
        .mode (mode_q),
        .i    (i_q),
        .f    (f_val)
    );

    // Extra top bit of the increment is the wrap (carry-out) flag.
    assign inc   = {1'b0, i_q} + {1'b0, step_q};
    assign latch = start && (state_q == S_IDLE || state_q == S_DONE);
    // busy is high exactly in the states where abort is honoured.
    assign kill  = abort && busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: state_d = S_TEST;
            S_TEST: state_d = (i_q < hi_q) ? S_BODY : S_EXIT;
            S_BODY: state_d = S_INCR;
            S_INCR: state_d = inc[WIDTH] ? S_EXIT : S_TEST;
            S_EXIT: state_d = S_DONE;
            S_DONE: if (start) state_d = S_INIT;
            default: state_d = S_IDLE;
        endcase
        if (kill) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= !(state_d == S_IDLE || state_d == S_DONE);
            finish  <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_SUM;
            lo_q     <= '0;
            hi_q     <= '0;
            step_q   <= '0;
            offset_q <= '0;
        end else if (latch) begin
            mode_q   <= mode;
            lo_q     <= lo;
            hi_q     <= hi;
            // A zero step would never terminate; run it as step 1.
            step_q   <= (step == '0) ? WIDTH'(1) : step;
            offset_q <= offset;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q     <= '0;
            acc_q   <= '0;
            ret     <= '0;
            iters   <= '0;
            wrapped <= 1'b0;
        end else if (!kill) begin
            case (state_q)
                S_INIT: begin
                    i_q     <= lo_q;
                    acc_q   <= '0;
                    iters   <= '0;
                    wrapped <= 1'b0;
                end
                S_BODY: begin
                    acc_q <= acc_q + f_val;
                    if (!(&iters)) iters <= iters + CNT_W'(1);
                end
                S_INCR: begin
                    i_q <= inc[WIDTH-1:0];
                    if (inc[WIDTH]) wrapped <= 1'b1;
                end
                S_EXIT: ret <= acc_q + offset_q;
                default: ;
            endcase
        end
    end

endmodule
